hmsg_sink: RTL
==============

# hmsg_sink

Terminal consumer for one message channel: accepts messages from an upstream source (e.g. a null or probe source) over the two-phase req/ack handshake and captures the last message. It counts received messages and, when checking is compiled in, validates destination address and redundancy. Sits at the leaf of a test or bring-up network, directly downstream of a source stage, and provides controllable backpressure for exercising upstream flow control.

## Interface
- MY_LOCAL_ADDR, 0, address this sink answers to
- ASZ, `NS_ADDRESS_SIZE, address field width
- DSZ, `NS_DATA_SIZE, data field width
- RSZ, `NS_REDUN_SIZE, redundancy field width
- ACK_DELAY, 0, extra cycles held before acknowledging (0..255)
- CNT_W, 16, width of message/error counters

- gch_clk  in  1  single clock, all logic on rising edge
- gch_reset  in  1  asynchronous, active-low reset
- gch_ready  out  1  sink initialised and accepting
- rcv0_src  in  ASZ  message source address
- rcv0_dst  in  ASZ  message destination address
- rcv0_dat  in  DSZ  message data
- rcv0_red  in  RSZ  message redundancy
- rcv0_req_in  in  1  request level (two-phase)
- rcv0_ack_out  out  1  acknowledge level (two-phase)
- stall_in  in  1  holds acknowledgement while high
- last_src  out  ASZ  source of last accepted message
- last_dat  out  DSZ  data of last accepted message
- rcv_cnt  out  CNT_W  accepted-message count
- err_cnt  out  CNT_W  checked-failure count
- err_flag  out  1  sticky: any check failed

## Operation
- Pending message: rcv0_req_in != rcv0_ack_out. Acceptance completes by toggling rcv0_ack_out.
- States: INIT, IDLE, HOLD.
  - INIT: entered on reset; gch_ready low; no acceptance; goes to IDLE on first edge after reset release.
  - IDLE: on pending, capture src/dat into last_*, increment rcv_cnt, run checks, load delay counter with ACK_DELAY, go HOLD. Otherwise stay.
  - HOLD: if delay counter == 0 and stall_in low: toggle rcv0_ack_out, go IDLE. Else decrement delay counter if nonzero; stay.
- Checks (CHECK_EN only): fail if rcv0_dst != MY_LOCAL_ADDR or rcv0_red != expected redundancy. Expected redundancy = low RSZ bits of (src + dst + dat), operands zero-extended to max(ASZ,DSZ)+2 bits. On failure increment err_cnt and set err_flag. Two failures in one message count once.
- Counters saturate at all-ones; no wrap.
- Field inputs sampled only on the IDLE acceptance edge; changes while in HOLD ignored.

## Timing
- Reset values: gch_ready 0, rcv0_ack_out 0, last_src 0, last_dat 0, rcv_cnt 0, err_cnt 0, err_flag 0, state INIT.
- gch_ready rises on first rising edge after gch_reset deasserts.
- Pending seen at edge t (IDLE): capture/counters update at t; ack toggles at edge t+1+ACK_DELAY minimum; each stall_in-high cycle at the would-be ack edge adds one cycle.
- Back-to-back: earliest next capture is one edge after the ack toggle; throughput with ACK_DELAY=0, no stall, zero-latency source: one message per 2 cycles.
- stall_in high in IDLE does not block capture, only ack.
- Reset mid-HOLD: immediate clear; the in-flight message is neither acked nor retained; upstream shares reset and returns req to 0.
- req toggling again before ack (protocol violation): not detected; treated as same message.

## Configuration
- NS_SINK_CHECK_EN defined: address/redundancy checks, err_cnt and err_flag logic present.
- Undefined: no check logic; err_cnt tied 0, err_flag tied 0; all other behaviour identical.

## Structure
- Shared package (hglobal.v): state encodings, width defaults, channel declaration macros, expected-redundancy formula as a shared macro so sources and sinks agree.
- One sub-module: hmsg_red_calc (combinational expected redundancy from src, dst, dat), instantiated only under NS_SINK_CHECK_EN.

## Test plan
- Reset release -> gch_ready 0 then 1 after one edge; ack 0, counters 0.
- ACK_DELAY=0, send dst=MY_LOCAL_ADDR, dat=0x5A, correct red -> ack toggles at t+1, rcv_cnt=1, last_dat=0x5A, err_cnt=0.
- ACK_DELAY=3, stall_in high 2 cycles after delay expires -> ack toggles at t+6.
- dst=MY_LOCAL_ADDR+1 and bad red (CHECK_EN) -> err_cnt=1, err_flag=1, rcv_cnt=1; without CHECK_EN err_cnt stays 0.
- CNT_W=4, send 20 messages -> rcv_cnt saturates at 15.
- Assert reset during HOLD -> ack 0, all counters 0, state INIT, no ack toggle emitted.

Source files
------------

// File: rtl/hmsg_sink_pkg.sv
// Shared definitions for the hmsg sink: default field widths and sink state encoding.
package hmsg_sink_pkg;

    localparam int NS_ADDRESS_SIZE = 8;
    localparam int NS_DATA_SIZE    = 8;
    localparam int NS_REDUN_SIZE   = 4;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_HOLD = 2'd2
    } sink_state_t;

endpackage

// File: rtl/hmsg_sink_red_calc.sv
// Expected redundancy: low RSZ bits of src + dst + dat, all zero-extended to max(ASZ,DSZ)+2 bits.
module hmsg_red_calc #(
    parameter int ASZ = 8,
    parameter int DSZ = 8,
    parameter int RSZ = 4
) (
    input  logic [ASZ-1:0] src,
    input  logic [ASZ-1:0] dst,
    input  logic [DSZ-1:0] dat,
    output logic [RSZ-1:0] red
);

    localparam int SW = ((ASZ > DSZ) ? ASZ : DSZ) + 2;

    assign red = RSZ'(SW'(src) + SW'(dst) + SW'(dat));

endmodule

// File: rtl/hmsg_sink.sv
// Leaf message sink on a two-phase req/ack channel with capture, counters and throttled ack.
// Define NS_SINK_CHECK_EN to build in destination/redundancy checking (err_cnt, err_flag).
module hmsg_sink
    import hmsg_sink_pkg::*;
#(
    parameter int MY_LOCAL_ADDR = 0,
    parameter int ASZ           = NS_ADDRESS_SIZE,
    parameter int DSZ           = NS_DATA_SIZE,
    parameter int RSZ           = NS_REDUN_SIZE,
    parameter int ACK_DELAY     = 0,
    parameter int CNT_W         = 16
) (
    input  logic             gch_clk,
    input  logic             gch_reset,
    output logic             gch_ready,
    input  logic [ASZ-1:0]   rcv0_src,
    input  logic [ASZ-1:0]   rcv0_dst,
    input  logic [DSZ-1:0]   rcv0_dat,
    input  logic [RSZ-1:0]   rcv0_red,
    input  logic             rcv0_req_in,
    output logic             rcv0_ack_out,
    input  logic             stall_in,
    output logic [ASZ-1:0]   last_src,
    output logic [DSZ-1:0]   last_dat,
    output logic [CNT_W-1:0] rcv_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_flag
);

    sink_state_t state;
    logic [7:0]  delay_cnt;
    logic        accept;

    assign accept = (state == ST_IDLE) && (rcv0_req_in != rcv0_ack_out);

    // Fields are only sampled on the accepting edge; the ack waits out the delay and any stall.
    always_ff @(posedge gch_clk or negedge gch_reset) begin
        if (!gch_reset) begin
            state        <= ST_INIT;
            gch_ready    <= 1'b0;
            rcv0_ack_out <= 1'b0;
            last_src     <= '0;
            last_dat     <= '0;
            rcv_cnt      <= '0;
            delay_cnt    <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    gch_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (accept) begin
                        last_src  <= rcv0_src;
                        last_dat  <= rcv0_dat;
                        if (rcv_cnt != '1)
                            rcv_cnt <= rcv_cnt + 1'b1;
                        delay_cnt <= 8'(ACK_DELAY);
                        state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (delay_cnt == 8'd0 && !stall_in) begin
                        rcv0_ack_out <= ~rcv0_ack_out;
                        state        <= ST_IDLE;
                    end else if (delay_cnt != 8'd0) begin
                        delay_cnt <= delay_cnt - 8'd1;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

`ifdef NS_SINK_CHECK_EN
    logic [RSZ-1:0] exp_red;
    logic           check_fail;

    hmsg_red_calc #(
        .ASZ(ASZ),
        .DSZ(DSZ),
        .RSZ(RSZ)
    ) u_red_calc (
        .src(rcv0_src),
        .dst(rcv0_dst),
        .dat(rcv0_dat),
        .red(exp_red)
    );

    assign check_fail = (rcv0_dst != ASZ'(MY_LOCAL_ADDR)) || (rcv0_red != exp_red);

    // A message with both a bad address and bad redundancy still counts as one error.
    always_ff @(posedge gch_clk or negedge gch_reset) begin
        if (!gch_reset) begin
            err_cnt  <= '0;
            err_flag <= 1'b0;
        end else if (accept && check_fail) begin
            err_flag <= 1'b1;
            if (err_cnt != '1)
                err_cnt <= err_cnt + 1'b1;
        end
    end
`else
    logic unused_fields;

    assign unused_fields = ^{rcv0_dst, rcv0_red};
    assign err_cnt       = '0;
    assign err_flag      = 1'b0;
`endif

endmodule
